// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit and presents one byte per good frame.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t          state, state_d;
    logic [1:0]      sync;
    logic            rx_s;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      idx, idx_d;
    logic [7:0]      sh, sh_d;
    logic [7:0]      data_d;
    logic            valid_d, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bad, par_bad_d;
    logic            parity_err_d;
`endif

    assign rx_s = sync[1];

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], rx};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            sh        <= sh_d;
            data      <= data_d;
            valid     <= valid_d;
            busy      <= (state_d != IDLE);
            frame_err <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_d;
            parity_err <= parity_err_d;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        cnt_d       = cnt + CW'(1);
        idx_d       = idx;
        sh_d        = sh;
        data_d      = data;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad;
        parity_err_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // Half-bit check rejects glitches and re-centres sampling mid-bit.
                if (cnt == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh[7:1]};
                    idx_d = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s ^ (^sh);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            parity_err_d = 1'b1;
                        end else begin
                            data_d  = sh;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = sh;
                        valid_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line must return high before another frame is accepted.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLKS_PER_BIT=4; parity cases enabled with UART_RX_PARITY_EN.
module tb_uart_rx_byte;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int vecs = 0;
    int errs = 0;

    int n_valid = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    int n_long  = 0;
    int n_excl  = 0;
    logic pv = 1'b0, pf = 1'b0, pp = 1'b0;
    logic [7:0] got[$];

    int nv, nf;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            got.push_back(data);
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if ((valid && pv) || (frame_err && pf) || (parity_err && pp)) n_long++;
        if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) n_excl++;
        pv = valid;
        pf = frame_err;
        pp = parity_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`else
        if (pbit === 1'bz) rx = 1'b1;
`endif
        drive_bit(stopb);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  32'(data), 32'h00);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_perr",  32'(parity_err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(3);

        // Single frame 0x88 with exact strobe timing.
        send_frame(8'h88, ^8'h88, 1'b1);
        @(negedge clk);
        chk("b88_busy_pre",  32'(busy), 32'd1);
        chk("b88_valid_pre", 32'(valid), 32'd0);
        @(negedge clk);
        chk("b88_valid", 32'(valid), 32'd1);
        chk("b88_data",  32'(data), 32'h88);
        chk("b88_busy",  32'(busy), 32'd0);
        chk("b88_ferr",  32'(frame_err), 32'd0);
        @(negedge clk);
        chk("b88_valid_off", 32'(valid), 32'd0);
        @(posedge clk);
        #1;
        idle(2);

        // Back-to-back frames with no idle gap.
        got.delete();
        send_frame(8'hFF, ^8'hFF, 1'b1);
        send_frame(8'h00, ^8'h00, 1'b1);
        send_frame(8'h09, ^8'h09, 1'b1);
        idle(4);
        chk("b2b_count", 32'(got.size()), 32'd3);
        chk("b2b_0", 32'((got.size() > 0) ? got[0] : 8'h5D), 32'hFF);
        chk("b2b_1", 32'((got.size() > 1) ? got[1] : 8'h5D), 32'h00);
        chk("b2b_2", 32'((got.size() > 2) ? got[2] : 8'h5D), 32'h09);
        chk("b2b_ferr", 32'(n_ferr), 32'd0);

        // One-cycle glitch: enters START, rejected at the half-bit check.
        nv = n_valid;
        nf = n_ferr;
        rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        idle(8);
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        chk("glitch_data",    32'(data), 32'h09);
        chk("glitch_valid_n", 32'(n_valid), 32'(nv));
        chk("glitch_ferr_n",  32'(n_ferr), 32'(nf));

        // Framing error then a long break.
        send_frame(8'h5A, ^8'h5A, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("brk_busy",    32'(busy), 32'd1);
        chk("brk_ferr_n",  32'(n_ferr), 32'(nf + 1));
        chk("brk_valid_n", 32'(n_valid), 32'(nv));
        chk("brk_data",    32'(data), 32'h09);
        @(posedge clk);
        #1;
        idle(6);
        chk("brk_busy_lo", 32'(busy), 32'd0);
        chk("brk_ferr_n2", 32'(n_ferr), 32'(nf + 1));
        chk("brk_valid_n2", 32'(n_valid), 32'(nv));

        // Reset during bit 4 aborts the frame immediately.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hA5 >> i));
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        chk("mid_rst_data",  32'(data), 32'h00);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(4);
        chk("mid_rst_valid_n", 32'(n_valid), 32'(nv));
        send_frame(8'h3C, ^8'h3C, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("b3c_valid", 32'(valid), 32'd1);
        chk("b3c_data",  32'(data), 32'h3C);
        @(posedge clk);
        #1;
        idle(3);
        chk("b3c_valid_n", 32'(n_valid), 32'(nv + 1));

`ifdef UART_RX_PARITY_EN
        nv = n_valid;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(3);
        chk("par_ok_valid_n", 32'(n_valid), 32'(nv + 1));
        chk("par_ok_data",    32'(data), 32'h07);
        chk("par_ok_perr_n",  32'(n_perr), 32'd0);
        send_frame(8'h07, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("par_bad_perr",  32'(parity_err), 32'd1);
        chk("par_bad_valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1;
        idle(3);
        chk("par_bad_perr_n",  32'(n_perr), 32'd1);
        chk("par_bad_valid_n", 32'(n_valid), 32'(nv + 1));
        chk("par_bad_data",    32'(data), 32'h07);
`else
        chk("noparity_perr_n", 32'(n_perr), 32'd0);
`endif

        chk("pulse_width", 32'(n_long), 32'd0);
        chk("pulse_excl",  32'(n_excl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial-to-parallel receive stage for the Basys3 board: samples the USB-UART RX pin (8N1, LSB first), reassembles one byte per frame and presents it on an 8-bit bus with a one-cycle strobe. It sits directly upstream of the byte-consuming bit-extraction logic, which reads `data` combinationally. Framing and optional parity errors are flagged and never produce a `valid` strobe.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud). Must be ≥ 4.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `data`  out  8  last correctly received byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse when `data` updates.
- `busy`  out  1  high in every state except IDLE.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer; all logic uses the synchronized `rx_s`.
- Bit counter `cnt` has width `$clog2(CLKS_PER_BIT)`. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: `rx_s`==0 → START, `cnt`←0.
- START: when `cnt`==CLKS_PER_BIT/2−1 (integer division), sample `rx_s`.
  - 1 → false start, back to IDLE, no outputs.
  - 0 → DATA, `cnt`←0, `idx`←0.
- DATA: when `cnt`==CLKS_PER_BIT−1, `sh`←{`rx_s`,`sh[7:1]`} (LSB first) and `cnt`←0. After `idx`==7 → PARITY (if enabled) or STOP.
- PARITY: sample at `cnt`==CLKS_PER_BIT−1; latch the mismatch flag; → STOP.
- STOP: sample at `cnt`==CLKS_PER_BIT−1.
  - `rx_s`==1 and no parity mismatch → `data`←`sh`, pulse `valid`, → IDLE.
  - `rx_s`==1 with a parity mismatch → pulse `parity_err`, `data` unchanged, → IDLE.
  - `rx_s`==0 → pulse `frame_err`, `data` unchanged, → BREAK.
- BREAK: wait for `rx_s`==1, then → IDLE. This prevents a held-low line from being decoded as a stream of 0x00 frames.
- `valid`, `frame_err` and `parity_err` are mutually exclusive and never high for more than one cycle.

## Timing
- Reset (async assert, sync-release safe): state IDLE, synchronizer flops 1, `cnt` 0, `sh` 0, `data` 8'h00, and `valid`, `busy`, `frame_err`, `parity_err` all 0.
- Reset asserted mid-frame aborts the frame with no strobe. After release, reception restarts at the next falling edge seen in IDLE. A line already low at release is accepted as a start bit only if it is still low at the half-bit check.
- Latency from the `rx` falling edge to the start check: 2 (synchronizer) + CLKS_PER_BIT/2 cycles.
- The data, parity and stop bits are each sampled one full bit period after the previous sample, i.e. mid-bit.
- `valid`/err outputs are registered: they assert the cycle after the stop-bit sample edge, and `data` is stable in that same cycle.
- Minimum frame spacing: a new start bit is detected from the cycle after returning to IDLE, so back-to-back frames with zero idle time beyond the stop bit are received.
- `busy` rises the cycle after the start edge is detected in IDLE. It falls in the cycle `valid`/err asserts, or when BREAK exits.

## Configuration
- `UART_RX_PARITY_EN`, when defined:
  - adds the PARITY state;
  - the frame is start, 8 data, one even-parity bit, stop;
  - `parity_err` is live.
- When undefined:
  - the frame is 8N1;
  - the PARITY state and the mismatch flag are not synthesized;
  - `parity_err` is tied to 0.

## Test plan
- Use CLKS_PER_BIT=4 for all scenarios.
- Send 0x88 8N1 → `data`==8'h88, `valid` high exactly one cycle, `busy` low afterwards, `frame_err`==0.
- Send 0xFF, 0x00, 0x09 back-to-back with no idle gap → three `valid` pulses with `data` 8'hFF, 8'h00, 8'h09 in order.
- Glitch: `rx` low for 1 cycle only → no state change beyond START, no strobes, `data` unchanged.
- Send 0x5A with the stop bit forced 0, then hold `rx` low for 40 cycles → one `frame_err` pulse, `data` still the previous value, no further strobes until `rx` returns high.
- Assert `reset` during bit 4 of a frame → all outputs 0 immediately. The next clean frame 0x3C → `valid` with `data`==8'h3C.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `valid`, `data`==8'h07. The same byte with parity bit 0 → `parity_err` pulse, no `valid`.
